// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } mem_arb_state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the shared memory port, bundled for the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wr_data0;
  logic [31:0] wr_data1;
  logic        wr_ena0;
  logic        wr_ena1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic        rd_valid0;
  logic        rd_valid1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  // Environment side: requesters and the memory model.
  modport master (
    output req0, req1, addr0, addr1, wr_data0, wr_data1, wr_ena0, wr_ena1,
    output mem_rd_data,
    input  gnt0, gnt1, rd_data0, rd_data1, rd_valid0, rd_valid1,
    input  mem_addr, mem_wr_data, mem_wr_ena
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, wr_data0, wr_data1, wr_ena0, wr_ena1,
    input  mem_rd_data,
    output gnt0, gnt1, rd_data0, rd_data1, rd_valid0, rd_valid1,
    output mem_addr, mem_wr_data, mem_wr_ena
  );

endinterface

// File: rtl/mem_port_arbiter_port_mux.sv
// 2:1 select of address / write data / write enable onto the memory port.
module mem_arb_port_mux
  import mem_port_arbiter_pkg::*;
(
  input  logic        sel,
  input  logic        granted,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wr_data0,
  input  logic [31:0] wr_data1,
  input  logic        wr_ena0,
  input  logic        wr_ena1,
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic        wr_ena
);

  // Route the selected requester; a write only reaches memory with a grant.
  always_comb begin
    addr    = (sel == REQ_LOADER) ? addr1 : addr0;
    wr_data = (sel == REQ_LOADER) ? wr_data1 : wr_data0;
    wr_ena  = granted && ((sel == REQ_LOADER) ? wr_ena1 : wr_ena0);
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-high reset.
module register #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port with burst-limited fairness.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST      = 4,
  parameter bit          FIRST_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                owner,
  output logic [31:0]         grants_issued
);

  localparam int unsigned       CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_LIMIT = CNT_W'(MAX_BURST);

  mem_arb_state_t   state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_owner;
  logic             gnt0;
  logic             gnt1;
  logic             granted;
  logic             sel;
  logic             rd_pend;
  logic             rd_tag;

  // Grant decision from the current owner, burst count and requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req0 && bus.req1) begin
          if (last_owner == REQ_LOADER) gnt0 = 1'b1;
          else                          gnt1 = 1'b1;
        end else begin
          gnt0 = bus.req0;
          gnt1 = bus.req1;
        end
      end
      S_OWN0: begin
        if (bus.req0 && (burst_cnt < BURST_LIMIT || !bus.req1)) gnt0 = 1'b1;
        else                                                    gnt1 = bus.req1;
      end
      S_OWN1: begin
        if (bus.req1 && (burst_cnt < BURST_LIMIT || !bus.req0)) gnt1 = 1'b1;
        else                                                    gnt0 = bus.req0;
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  assign granted = gnt0 || gnt1;
  // Without a grant the port stays on the last owner so the address is stable.
  assign sel     = granted ? gnt1 : last_owner;

  // Ownership, burst counting and last-owner tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      burst_cnt  <= '0;
      last_owner <= ~FIRST_PRIORITY;
      owner      <= FIRST_PRIORITY;
    end else if (granted) begin
      state      <= gnt1 ? S_OWN1 : S_OWN0;
      last_owner <= gnt1;
      owner      <= gnt1;
      if ((state == S_OWN0 && gnt0) || (state == S_OWN1 && gnt1)) begin
        burst_cnt <= (burst_cnt == BURST_LIMIT) ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        burst_cnt <= CNT_W'(1);
      end
    end else begin
      state <= S_IDLE;
    end
  end

  // Remember a granted read and its requester for the next-cycle valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_tag  <= REQ_CORE;
    end else begin
      rd_pend <= granted && !bus.mem_wr_ena;
      if (granted) rd_tag <= gnt1;
    end
  end

  mem_arb_port_mux u_mux (
    .sel      (sel),
    .granted  (granted),
    .addr0    (bus.addr0),
    .addr1    (bus.addr1),
    .wr_data0 (bus.wr_data0),
    .wr_data1 (bus.wr_data1),
    .wr_ena0  (bus.wr_ena0),
    .wr_ena1  (bus.wr_ena1),
    .addr     (bus.mem_addr),
    .wr_data  (bus.mem_wr_data),
    .wr_ena   (bus.mem_wr_ena)
  );

  register #(
    .WIDTH       (32),
    .RESET_VALUE (32'd0)
  ) u_grants (
    .clk (clk),
    .rst (rst),
    .ena (granted),
    .d   (grants_issued + 32'd1),
    .q   (grants_issued)
  );

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rd_data0  = bus.mem_rd_data;
  assign bus.rd_data1  = bus.mem_rd_data;
  assign bus.rd_valid0 = rd_pend && (rd_tag == REQ_CORE);
  assign bus.rd_valid1 = rd_pend && (rd_tag == REQ_LOADER);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: vector table, corner sequences, random vs reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst;
  logic        owner;
  logic [31:0] grants_issued;

  mem_port_arbiter_if bif ();

  mem_port_arbiter #(
    .MAX_BURST      (MAXB),
    .FIRST_PRIORITY (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bif),
    .owner         (owner),
    .grants_issued (grants_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous read, read-before-write
  logic [31:0] mem_arr [256];
  always @(posedge clk) begin
    if (bif.mem_wr_ena) mem_arr[bif.mem_addr[9:2]] <= bif.mem_wr_data;
    bif.mem_rd_data <= mem_arr[bif.mem_addr[9:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_busy;
  bit          m_cur;
  int          m_run;
  bit          m_last;
  bit          m_owner;
  int unsigned m_cnt;
  bit          m_pend;
  bit          m_tag;
  logic [31:0] m_data;
  logic [31:0] m_mem [256];

  function automatic void m_reset();
    m_busy  = 1'b0;
    m_run   = 0;
    m_last  = 1'b1;
    m_owner = 1'b0;
    m_cnt   = 0;
    m_pend  = 1'b0;
  endfunction

  // Returns {gnt1, gnt0} for the current requests.
  function automatic logic [1:0] model_grant();
    bit r0, r1, mine, other;
    r0 = bif.req0;
    r1 = bif.req1;
    if (!m_busy) begin
      if (r0 && r1) return m_last ? 2'b01 : 2'b10;
      return {r1, r0};
    end
    mine  = m_cur ? r1 : r0;
    other = m_cur ? r0 : r1;
    if (mine && (m_run < MAXB || !other)) return m_cur ? 2'b10 : 2'b01;
    if (other) return m_cur ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic check_model();
    logic [1:0] g;
    logic       k;
    logic       we;
    g  = model_grant();
    k  = g[0] ? 1'b0 : (g[1] ? 1'b1 : m_last);
    we = (g != 2'b00) && (k ? bif.wr_ena1 : bif.wr_ena0);
    check("m_gnt0", bif.gnt0, g[0]);
    check("m_gnt1", bif.gnt1, g[1]);
    check("m_one_hot", bif.gnt0 & bif.gnt1, 0);
    check("m_addr", bif.mem_addr, k ? bif.addr1 : bif.addr0);
    check("m_we", bif.mem_wr_ena, we);
    if (we) check("m_wdata", bif.mem_wr_data, k ? bif.wr_data1 : bif.wr_data0);
    check("m_valid0", bif.rd_valid0, m_pend && !m_tag);
    check("m_valid1", bif.rd_valid1, m_pend && m_tag);
    if (m_pend) check("m_rdata", m_tag ? bif.rd_data1 : bif.rd_data0, m_data);
    check("m_owner", owner, m_owner);
    check("m_grants", grants_issued, m_cnt);
  endtask

  // Advance the model across the coming clock edge.
  function automatic void model_step();
    logic [1:0]  g;
    bit          k;
    logic [31:0] a;
    g = model_grant();
    if (g == 2'b00) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      return;
    end
    k       = g[1];
    m_run   = (m_busy && m_cur == k) ? m_run + 1 : 1;
    m_busy  = 1'b1;
    m_cur   = k;
    m_last  = k;
    m_owner = k;
    m_cnt++;
    a = k ? bif.addr1 : bif.addr0;
    if (k ? bif.wr_ena1 : bif.wr_ena0) begin
      m_mem[a[9:2]] = k ? bif.wr_data1 : bif.wr_data0;
      m_pend = 1'b0;
    end else begin
      m_pend = 1'b1;
      m_tag  = k;
      m_data = m_mem[a[9:2]];
    end
  endfunction

  task automatic drive(input logic r0, input logic r1, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic w0, input logic w1);
    bif.req0 = r0; bif.req1 = r1;
    bif.addr0 = a0; bif.addr1 = a1;
    bif.wr_data0 = d0; bif.wr_data1 = d1;
    bif.wr_ena0 = w0; bif.wr_ena1 = w1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    rst = 1'b1;
    m_reset();
    #2;
    check("rst_gnt0", bif.gnt0, 0);
    check("rst_gnt1", bif.gnt1, 0);
    check("rst_we", bif.mem_wr_ena, 0);
    check("rst_valid", {bif.rd_valid1, bif.rd_valid0}, 0);
    check("rst_owner", owner, 0);
    check("rst_grants", grants_issued, 0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1, d0, d1;
    logic        w0, w1;
    logic        eg0, eg1, ewe;
    logic [31:0] eaddr;
    logic        ev0, ev1;
    logic [31:0] erd;
    int          ecnt;
  } vec_t;

  function automatic vec_t mk(logic r0, logic r1, logic [31:0] a0, logic [31:0] a1, logic [31:0] d1,
                              logic w1, logic eg0, logic eg1, logic ewe, logic [31:0] eaddr,
                              logic ev0, logic ev1, logic [31:0] erd, int ecnt);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.d0 = 32'h0; v.d1 = d1;
    v.w0 = 1'b0; v.w1 = w1; v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.eaddr = eaddr;
    v.ev0 = ev0; v.ev1 = ev1; v.erd = erd; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tv [13];
  int   pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'h1000_0000 + 32'(i * 4);
      m_mem[i]   = 32'h1000_0000 + 32'(i * 4);
    end
    rst = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    #1;

    // Vector table: reads, a loader write, read-back, alternating reads
    //             r0 r1 a0        a1        d1            w1 g0 g1 we addr      v0 v1 rd            cnt
    tv[0]  = mk(1, 0, 32'h000, 32'h000, 32'h0,        0, 1, 0, 0, 32'h000, 0, 0, 32'h0,        0);
    tv[1]  = mk(1, 0, 32'h004, 32'h000, 32'h0,        0, 1, 0, 0, 32'h004, 1, 0, 32'h10000000, 1);
    tv[2]  = mk(1, 0, 32'h008, 32'h000, 32'h0,        0, 1, 0, 0, 32'h008, 1, 0, 32'h10000004, 2);
    tv[3]  = mk(0, 0, 32'h008, 32'h100, 32'h0,        0, 0, 0, 0, 32'h008, 1, 0, 32'h10000008, 3);
    tv[4]  = mk(0, 1, 32'h008, 32'h100, 32'hDEADBEEF, 1, 0, 1, 1, 32'h100, 0, 0, 32'h0,        3);
    tv[5]  = mk(0, 0, 32'h008, 32'h100, 32'h0,        0, 0, 0, 0, 32'h100, 0, 0, 32'h0,        4);
    tv[6]  = mk(1, 0, 32'h100, 32'h000, 32'h0,        0, 1, 0, 0, 32'h100, 0, 0, 32'h0,        4);
    tv[7]  = mk(0, 0, 32'h100, 32'h000, 32'h0,        0, 0, 0, 0, 32'h100, 1, 0, 32'hDEADBEEF, 5);
    tv[8]  = mk(1, 0, 32'h010, 32'h000, 32'h0,        0, 1, 0, 0, 32'h010, 0, 0, 32'h0,        5);
    tv[9]  = mk(0, 1, 32'h010, 32'h014, 32'h0,        0, 0, 1, 0, 32'h014, 1, 0, 32'h10000010, 6);
    tv[10] = mk(1, 0, 32'h018, 32'h014, 32'h0,        0, 1, 0, 0, 32'h018, 0, 1, 32'h10000014, 7);
    tv[11] = mk(0, 1, 32'h018, 32'h01C, 32'h0,        0, 0, 1, 0, 32'h01C, 1, 0, 32'h10000018, 8);
    tv[12] = mk(0, 0, 32'h018, 32'h01C, 32'h0,        0, 0, 0, 0, 32'h01C, 0, 1, 32'h1000001C, 9);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].r0, tv[i].r1, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1, tv[i].w0, tv[i].w1);
      #1;
      check($sformatf("tv%0d_gnt0", i), bif.gnt0, tv[i].eg0);
      check($sformatf("tv%0d_gnt1", i), bif.gnt1, tv[i].eg1);
      check($sformatf("tv%0d_we", i), bif.mem_wr_ena, tv[i].ewe);
      check($sformatf("tv%0d_addr", i), bif.mem_addr, tv[i].eaddr);
      check($sformatf("tv%0d_v0", i), bif.rd_valid0, tv[i].ev0);
      check($sformatf("tv%0d_v1", i), bif.rd_valid1, tv[i].ev1);
      if (tv[i].ev0) check($sformatf("tv%0d_rd0", i), bif.rd_data0, tv[i].erd);
      if (tv[i].ev1) check($sformatf("tv%0d_rd1", i), bif.rd_data1, tv[i].erd);
      check($sformatf("tv%0d_cnt", i), grants_issued, tv[i].ecnt);
      check_model();
      tick();
    end

    // Both requesters held from reset: 4 grants each, alternating owners
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 32'h020, 32'h040, 32'h0, 32'h0, 0, 0);
      #1;
      check($sformatf("burst%0d_gnt1", i), bif.gnt1, pat[i] == 1);
      check($sformatf("burst%0d_gnt0", i), bif.gnt0, pat[i] == 0);
      check_model();
      tick();
    end

    // Owner at the burst limit; the waiter wins, but a dropped request lets the owner continue
    do_reset();
    for (int i = 0; i < MAXB; i++) begin
      drive(1, 0, 32'(i * 4), 32'h080, 32'h0, 32'h0, 0, 0);
      #1;
      check_model();
      tick();
    end
    drive(1, 1, 32'h030, 32'h080, 32'h0, 32'h0, 0, 0);
    #1;
    check("limit_waiter_wins", bif.gnt1, 1);
    check("limit_owner_yields", bif.gnt0, 0);
    bif.req1 = 1'b0;
    #1;
    check("drop_owner_continues", bif.gnt0, 1);
    check_model();
    tick();
    check("burst_saturated", 32'(dut.burst_cnt), MAXB);
    check("still_own0", 32'(dut.state), 32'(S_OWN0));
    drive(1, 0, 32'h034, 32'h080, 32'h0, 32'h0, 0, 0);
    #1;
    check("sat_next_gnt0", bif.gnt0, 1);
    check_model();
    tick();

    // Reset pulsed while a loader read response is in flight
    do_reset();
    drive(0, 1, 32'h0, 32'h040, 32'h0, 32'h0, 0, 0);
    #1;
    check_model();
    tick();
    drive(0, 0, 32'h0, 32'h040, 32'h0, 32'h0, 0, 0);
    rst = 1'b1;
    m_reset();
    #1;
    check("inflight_valid1", bif.rd_valid1, 0);
    check("inflight_grants", grants_issued, 0);
    check("inflight_state", 32'(dut.state), 32'(S_IDLE));
    check("inflight_burst", 32'(dut.burst_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_valid1", bif.rd_valid1, 0);
    check_model();
    tick();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            {22'h0, 8'($urandom_range(0, 255)), 2'b00}, {22'h0, 8'($urandom_range(0, 255)), 2'b00},
            $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      #1;
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single unified memory port between the multicycle core (requester 0) and a loader/debug master (requester 1). Each cycle it grants at most one requester, drives the memory address, write-data and write-enable from that requester, and routes the synchronous read data back with a one-cycle-delayed valid. When the other requester is waiting, a burst limit forces the current owner to yield, so neither side starves. It sits between `rv32i_multicycle_core` plus the loader and the memory model; the core's `ena` is driven from `gnt0`.

## Interface
- `MAX_BURST`, 4: maximum consecutive granted transfers one owner gets while the other requester is waiting; must be ≥1.
- `FIRST_PRIORITY`, 0: requester that wins a simultaneous request in the first arbitration after reset.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0`, `req1`  in  1  transfer request, held until granted.
- `addr0`, `addr1`  in  32  byte address.
- `wr_data0`, `wr_data1`  in  32  store data.
- `wr_ena0`, `wr_ena1`  in  1  1 = write, 0 = read.
- `gnt0`, `gnt1`  out  1  combinational grant; a transfer occurs in any cycle with `reqN && gntN`.
- `rd_data0`, `rd_data1`  out  32  equal to `mem_rd_data`; only meaningful while the matching valid is high.
- `rd_valid0`, `rd_valid1`  out  1  high one cycle after a granted read by that requester.
- `mem_addr`  out  32  memory address.
- `mem_wr_data`  out  32  memory write data.
- `mem_wr_ena`  out  1  memory write enable.
- `mem_rd_data`  in  32  synchronous read data, valid one cycle after the address is presented.
- `owner`  out  1  requester that received the most recent grant.
- `grants_issued`  out  32  count of granted transfers; wraps modulo 2^32.

## Operation
- FSM states: `S_IDLE` (no grant last cycle), `S_OWN0`, `S_OWN1`. Registered alongside it: `burst_cnt` (width $clog2(MAX_BURST+1), saturating) and `last_owner`.
- Grant rule, evaluated combinationally each cycle:
  - In `S_IDLE`, if only one requester is asserting, it is granted.
  - In `S_IDLE` with both requesting, grant `~last_owner`. Reset sets `last_owner = ~FIRST_PRIORITY`.
  - In `S_OWNk`, grant k if `reqk && (burst_cnt < MAX_BURST || !req_other)`.
  - Otherwise in `S_OWNk`, if `req_other`, grant the other requester.
  - Otherwise no grant.
- At most one of `gnt0`/`gnt1` is high in any cycle.
- Next state:
  - Grant to k → `S_OWNk` and `last_owner <= k`.
  - If that grant is a continuation of the current owner, `burst_cnt` increments (saturating); on a change of owner or from `S_IDLE`, `burst_cnt <= 1`.
  - No grant → `S_IDLE`; `burst_cnt` is held.
- Memory mux:
  - `mem_addr` and `mem_wr_data` come from the granted requester.
  - With no grant, they come from `last_owner`, which keeps the address stable.
  - `mem_wr_ena = granted && wr_enaN`, never asserted without a grant.
- Read return: a granted read sets the `rd_pend` flag and the `rd_tag = N` register; in the next cycle `rd_validN = 1`. Back-to-back reads produce back-to-back valids. A write never raises a valid.
- `grants_issued` increments on every granted transfer.

## Timing
- Grant latency is zero cycles: a request asserted into an idle arbiter is granted in the same cycle.
- Read data latency is one cycle after the grant.
- Simultaneous request from an owner that has reached `MAX_BURST` and from a waiting requester: the waiting side wins.
- If the waiting requester drops its request in that same cycle, the owner continues and `burst_cnt` stays saturated.
- Asynchronous reset, including during a transfer:
  - State: FSM `S_IDLE`, `burst_cnt = 0`, `last_owner = ~FIRST_PRIORITY`.
  - Read tracking: `rd_pend = 0`, `rd_valid0/1 = 0`; any in-flight read response is discarded.
  - Outputs: `grants_issued = 0`, `owner = FIRST_PRIORITY`. `gnt0`/`gnt1` are 0 unless requests are high after reset is released. Memory outputs carry the `last_owner` port's inputs, and `mem_wr_ena = 0`.
- A requester deasserting `req` without being granted has no effect.

## Structure
- Shared package: a `mem_arb_state_t` enum for `S_IDLE`/`S_OWN0`/`S_OWN1`, and the `REQ_CORE = 0`/`REQ_LOADER = 1` constants.
- `grants_issued` uses the existing `register` module with `ena = granted`.
- One natural sub-module: `mem_arb_port_mux`, the combinational 2:1 select of addr/wr_data/wr_ena.
- All other logic is flat in `mem_port_arbiter`.

## Test plan
- Only `req0` high with reads at 0x0, 0x4, 0x8: `gnt0 = 1` in each cycle, `rd_valid0` follows one cycle later with the memory words, and `grants_issued` reaches 3.
- Both requesters held high from reset with `FIRST_PRIORITY = 0` and `MAX_BURST = 4`: grants are 0,0,0,0,1,1,1,1,0…, and no cycle has both grants high.
- `req1` writes 0xDEADBEEF to 0x100 while `req0` is idle: `mem_wr_ena = 1` for exactly one cycle with `mem_addr = 0x100`, and no `rd_valid` is raised. A subsequent read of 0x100 by requester 0 returns 0xDEADBEEF.
- Requester 0 has been the owner for 4 transfers; `req1` rises and falls in the same cycle that requester 0 still requests: `gnt0` continues and `burst_cnt` stays at 4.
- `rst` is pulsed in the cycle after a granted read by requester 1: `rd_valid1` stays 0, `grants_issued = 0`, and the FSM is in `S_IDLE`.
- Alternating single reads 0,1,0,1: valids alternate on the correct port with the correct data.
